// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared widths, defaults and MEM-stage FSM encoding for the ARM pipeline
// Contents: DATA_W, REG_IDX_W, DEF_BASE_ADDR, mem_state_t {IDLE, BUSY, DONE}
package arm_pkg;

    localparam int DATA_W        = 32;
    localparam int REG_IDX_W     = 4;
    localparam int DEF_BASE_ADDR = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_stage_module_if.sv
// rtl/mem_stage_module_if.sv - EXE-to-MEM request fields and MEM/WB result fields of the memory stage
// master: EXE side, drives WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, ALU_result_IN, ST_val, Dest_IN
//         and observes WB_EN, MEM_R_EN, ALU_result, Mem_read_value, Dest, freeze
// slave : memory stage, the reverse directions
interface mem_stage_module_if;
    import arm_pkg::*;

    logic                 WB_EN_IN;
    logic                 MEM_R_EN_IN;
    logic                 MEM_W_EN_IN;
    logic [DATA_W-1:0]    ALU_result_IN;
    logic [DATA_W-1:0]    ST_val;
    logic [REG_IDX_W-1:0] Dest_IN;

    logic                 WB_EN;
    logic                 MEM_R_EN;
    logic [DATA_W-1:0]    ALU_result;
    logic [DATA_W-1:0]    Mem_read_value;
    logic [REG_IDX_W-1:0] Dest;
    logic                 freeze;

    modport master (
        output WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, ALU_result_IN, ST_val, Dest_IN,
        input  WB_EN, MEM_R_EN, ALU_result, Mem_read_value, Dest, freeze
    );

    modport slave (
        input  WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, ALU_result_IN, ST_val, Dest_IN,
        output WB_EN, MEM_R_EN, ALU_result, Mem_read_value, Dest, freeze
    );

endinterface

// File: rtl/mem_stage_reg.sv
// rtl/mem_stage_reg.sv - MEM/WB pipeline register with load and bubble controls
// Inputs : clk, rst (sync, active high), load, bubble, wb_en_in, mem_r_en_in, alu_result_in,
//          dest_in, rd_valid, rd_data
// Outputs: wb_en, mem_r_en, alu_result, mem_read_value, dest
module mem_stage_reg
    import arm_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 bubble,
    input  logic                 wb_en_in,
    input  logic                 mem_r_en_in,
    input  logic [DATA_W-1:0]    alu_result_in,
    input  logic [REG_IDX_W-1:0] dest_in,
    input  logic                 rd_valid,
    input  logic [DATA_W-1:0]    rd_data,
    output logic                 wb_en,
    output logic                 mem_r_en,
    output logic [DATA_W-1:0]    alu_result,
    output logic [DATA_W-1:0]    mem_read_value,
    output logic [REG_IDX_W-1:0] dest
);

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en          <= 1'b0;
            mem_r_en       <= 1'b0;
            alu_result     <= '0;
            mem_read_value <= '0;
            dest           <= '0;
        end else if (bubble) begin
            // Kill the control bits only; data fields hold so WB sees a harmless no-op.
            wb_en    <= 1'b0;
            mem_r_en <= 1'b0;
        end else if (load) begin
            wb_en      <= wb_en_in;
            mem_r_en   <= mem_r_en_in;
            alu_result <= alu_result_in;
            dest       <= dest_in;
            // Load data only moves when a load actually retires.
            if (rd_valid) begin
                mem_read_value <= rd_data;
            end
        end
    end

endmodule

// File: rtl/mem_stage_module.sv
// rtl/mem_stage_module.sv - ARM MEM stage: fixed-latency word memory, access FSM and MEM/WB register
// Params : DEPTH (words, power of two), WAIT_CYCLES (stall cycles per access), BASE_ADDR (byte addr of word 0)
// Ports  : clk, rst (sync, active high), bus (mem_stage_module_if.slave: EXE fields in, MEM/WB fields and freeze out)
module mem_stage_module
    import arm_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 4,
    parameter int BASE_ADDR   = DEF_BASE_ADDR
) (
    input  logic               clk,
    input  logic               rst,
    mem_stage_module_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_BUSY = 2'(BUSY);
    localparam logic [1:0] ST_DONE = 2'(DONE);

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_next;
    logic              req;
    logic              retire;
    logic              freeze_c;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] addr_off;
    logic [AW-1:0]     idx;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic              rd_valid;
    logic              unused_addr_bits;

    assign req = bus.MEM_R_EN_IN | bus.MEM_W_EN_IN;

    // Byte offset from the window base; the low two bits and everything above the
    // word index are dropped, which gives both alignment masking and modulo-DEPTH wrap.
    assign addr_off         = bus.ALU_result_IN - DATA_W'(BASE_ADDR);
    assign idx              = addr_off[AW+1:2];
    assign unused_addr_bits = ^{addr_off[DATA_W-1:AW+2], addr_off[1:0]};

    // The first stall cycle is spent in IDLE, so the counter starts at 1 on entry to the
    // wait and DONE is reached once WAIT_CYCLES stall cycles have elapsed.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        freeze_c   = 1'b0;
        retire     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        retire = 1'b1;
                    end else begin
                        freeze_c   = 1'b1;
                        cnt_next   = CW'(1);
                        state_next = (WAIT_CYCLES > 1) ? ST_BUSY : ST_DONE;
                    end
                end
            end
            ST_BUSY: begin
                freeze_c = 1'b1;
                cnt_next = cnt + CW'(1);
                if (cnt_next == CW'(WAIT_CYCLES)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                retire     = 1'b1;
                cnt_next   = '0;
                state_next = ST_IDLE;
            end
            default: begin
                cnt_next   = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Store wins over a (illegal) simultaneous load; reset aborts a pending write.
    assign wr_en    = retire & bus.MEM_W_EN_IN & ~rst;
    assign rd_valid = retire & bus.MEM_R_EN_IN & ~bus.MEM_W_EN_IN;
    assign rd_data  = mem[idx];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= bus.ST_val;
        end
    end

    assign bus.freeze = freeze_c;

    mem_stage_reg u_mem_wb (
        .clk            (clk),
        .rst            (rst),
        .load           (~freeze_c),
        .bubble         (freeze_c),
        .wb_en_in       (bus.WB_EN_IN),
        .mem_r_en_in    (bus.MEM_R_EN_IN & ~bus.MEM_W_EN_IN),
        .alu_result_in  (bus.ALU_result_IN),
        .dest_in        (bus.Dest_IN),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .wb_en          (bus.WB_EN),
        .mem_r_en       (bus.MEM_R_EN),
        .alu_result     (bus.ALU_result),
        .mem_read_value (bus.Mem_read_value),
        .dest           (bus.Dest)
    );

endmodule

// File: tb/tb_mem_stage_module.sv
// tb/tb_mem_stage_module.sv - self-checking bench for mem_stage_module (WAIT_CYCLES=4 and WAIT_CYCLES=0 builds)
module tb_mem_stage_module;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mem_stage_module_if bus ();
    mem_stage_module_if bus0 ();

    mem_stage_module #(.DEPTH(64), .WAIT_CYCLES(4), .BASE_ADDR(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_stage_module #(.DEPTH(64), .WAIT_CYCLES(0), .BASE_ADDR(1024)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: word memory plus the expected MEM/WB contents.
    logic [31:0] mdl_mem [64];
    bit          mdl_ok  [64];
    logic [31:0] exp_rd;
    int          exp_frz;
    logic [69:0] exp_vec;

    int          obs_frz;
    int          obs_bub;
    logic [69:0] obs_vec;

    function automatic int widx(input logic [31:0] a);
        logic [31:0] d;
        d = a - 32'd1024;
        return int'((d >> 2) % 32'd64);
    endfunction

    task automatic model_access(input bit we, input bit re, input bit wb, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] dest);
        int i;
        i = widx(addr);
        exp_frz = (we || re) ? 4 : 0;
        if (re && !we) exp_rd = mdl_mem[i];
        if (we) begin
            mdl_mem[i] = data;
            mdl_ok[i]  = 1'b1;
        end
        exp_vec = {wb, (re && !we), dest, addr, exp_rd};
    endtask

    task automatic idle_inputs();
        bus.WB_EN_IN = 0; bus.MEM_R_EN_IN = 0; bus.MEM_W_EN_IN = 0;
        bus.ALU_result_IN = 0; bus.ST_val = 0; bus.Dest_IN = 0;
        bus0.WB_EN_IN = 0; bus0.MEM_R_EN_IN = 0; bus0.MEM_W_EN_IN = 0;
        bus0.ALU_result_IN = 0; bus0.ST_val = 0; bus0.Dest_IN = 0;
    endtask

    // Drives one request and holds it through the stall, measuring stall length and bubbles.
    task automatic run_access(input bit we, input bit re, input bit wb, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] dest);
        logic [31:0] alu0;
        alu0 = 0;
        @(posedge clk); #1;
        bus.WB_EN_IN = wb; bus.MEM_R_EN_IN = re; bus.MEM_W_EN_IN = we;
        bus.ALU_result_IN = addr; bus.ST_val = data; bus.Dest_IN = dest;
        obs_frz = 0;
        obs_bub = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (!bus.freeze) break;
            if (c == 0) alu0 = bus.ALU_result;
            else if (bus.WB_EN !== 1'b0 || bus.MEM_R_EN !== 1'b0 || bus.ALU_result !== alu0) obs_bub++;
            obs_frz++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        obs_vec = {bus.WB_EN, bus.MEM_R_EN, bus.Dest, bus.ALU_result, bus.Mem_read_value};
        idle_inputs();
        model_access(we, re, wb, addr, data, dest);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_rd = 0;
        @(negedge clk);
        n_cmp++;
        if ({bus.freeze, bus.WB_EN, bus.MEM_R_EN, bus.Dest, bus.ALU_result, bus.Mem_read_value} !== 71'd0) begin
            n_bad++;
            $display("FAIL reset_main got %h want 0", {bus.freeze, bus.WB_EN, bus.MEM_R_EN, bus.Dest, bus.ALU_result, bus.Mem_read_value});
        end
        n_cmp++;
        if ({bus0.freeze, bus0.WB_EN, bus0.MEM_R_EN, bus0.Dest, bus0.ALU_result, bus0.Mem_read_value} !== 71'd0) begin
            n_bad++;
            $display("FAIL reset_wait0 got %h want 0", {bus0.freeze, bus0.WB_EN, bus0.MEM_R_EN, bus0.Dest, bus0.ALU_result, bus0.Mem_read_value});
        end
    endtask

    task automatic test_alu_passthrough();
        run_access(0, 0, 1, 32'h0000_00AB, 32'h0, 4'd3);
        n_cmp++;
        if (obs_frz !== exp_frz) begin n_bad++; $display("FAIL alu_freeze got %0d want %0d", obs_frz, exp_frz); end
        n_cmp++;
        if (obs_vec !== exp_vec) begin n_bad++; $display("FAIL alu_outputs got %h want %h", obs_vec, exp_vec); end
    endtask

    task automatic test_store_load();
        run_access(1, 0, 0, 32'd1028, 32'hDEAD_BEEF, 4'd0);
        n_cmp++;
        if (obs_frz !== exp_frz) begin n_bad++; $display("FAIL store_freeze got %0d want %0d", obs_frz, exp_frz); end
        n_cmp++;
        if (obs_vec !== exp_vec) begin n_bad++; $display("FAIL store_outputs got %h want %h", obs_vec, exp_vec); end
        run_access(0, 1, 1, 32'd1028, 32'h0, 4'd5);
        n_cmp++;
        if (obs_frz !== exp_frz) begin n_bad++; $display("FAIL load_freeze got %0d want %0d", obs_frz, exp_frz); end
        n_cmp++;
        if (obs_bub !== 0) begin n_bad++; $display("FAIL load_bubble got %0d bad cycles want 0", obs_bub); end
        n_cmp++;
        if (obs_vec !== {1'b1, 1'b1, 4'd5, 32'd1028, 32'hDEAD_BEEF}) begin
            n_bad++; $display("FAIL load_outputs got %h want %h", obs_vec, {1'b1, 1'b1, 4'd5, 32'd1028, 32'hDEAD_BEEF});
        end
    endtask

    task automatic test_wrap_align();
        run_access(1, 0, 0, 32'd1282, 32'h1111_2222, 4'd0);
        n_cmp++;
        if (obs_vec !== exp_vec) begin n_bad++; $display("FAIL wrap_store got %h want %h", obs_vec, exp_vec); end
        run_access(0, 1, 1, 32'd1024, 32'h0, 4'd6);
        n_cmp++;
        if (obs_vec[31:0] !== 32'h1111_2222) begin n_bad++; $display("FAIL wrap_load got %h want 11112222", obs_vec[31:0]); end
    endtask

    task automatic test_store_priority();
        run_access(1, 1, 0, 32'd1044, 32'hA5A5_0F0F, 4'd2);
        n_cmp++;
        if (obs_vec !== exp_vec) begin n_bad++; $display("FAIL prio_outputs got %h want %h", obs_vec, exp_vec); end
        run_access(0, 1, 1, 32'd1044, 32'h0, 4'd4);
        n_cmp++;
        if (obs_vec !== exp_vec) begin n_bad++; $display("FAIL prio_load got %h want %h", obs_vec, exp_vec); end
    endtask

    task automatic test_reset_mid_access();
        run_access(1, 0, 0, 32'd1032, 32'hCAFE_0001, 4'd0);
        n_cmp++;
        if (obs_vec !== exp_vec) begin n_bad++; $display("FAIL abort_setup got %h want %h", obs_vec, exp_vec); end
        // Abort once in the second BUSY cycle (cycle 2) and once in DONE (cycle 4).
        for (int k = 0; k < 2; k++) begin
            int abort_cyc;
            abort_cyc = (k == 0) ? 2 : 4;
            @(posedge clk); #1;
            bus.MEM_W_EN_IN = 1; bus.ALU_result_IN = 32'd1032;
            bus.ST_val = (k == 0) ? 32'h5555_5555 : 32'h6666_6666;
            repeat (abort_cyc) begin @(posedge clk); #1; end
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            idle_inputs();
            exp_rd = 0;
            @(negedge clk);
            n_cmp++;
            if ({bus.freeze, bus.WB_EN, bus.MEM_R_EN, bus.Dest, bus.ALU_result, bus.Mem_read_value} !== 71'd0) begin
                n_bad++;
                $display("FAIL abort_state cyc %0d got %h want 0", abort_cyc, {bus.freeze, bus.WB_EN, bus.MEM_R_EN, bus.Dest, bus.ALU_result, bus.Mem_read_value});
            end
        end
        run_access(0, 1, 1, 32'd1032, 32'h0, 4'd8);
        n_cmp++;
        if (obs_vec[31:0] !== 32'hCAFE_0001) begin n_bad++; $display("FAIL abort_old_value got %h want cafe0001", obs_vec[31:0]); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            int kind, i;
            bit we, re, wb;
            logic [31:0] addr, data;
            logic [3:0] dest;
            kind = $urandom_range(0, 2);
            i    = $urandom_range(0, 63);
            if (kind == 2) begin
                int t;
                for (t = 0; t < 64 && !mdl_ok[(i + t) % 64]; t++) ;
                if (t == 64) kind = 1;
                else i = (i + t) % 64;
            end
            data = $urandom;
            dest = 4'($urandom_range(0, 15));
            wb   = 1'($urandom_range(0, 1));
            we   = (kind == 1);
            re   = (kind == 2);
            if (kind == 0) addr = $urandom;
            else addr = 32'(1024 + 4 * i + 256 * $urandom_range(0, 7) + $urandom_range(0, 3));
            if (we) wb = 0;
            run_access(we, re, wb, addr, data, dest);
            n_cmp++;
            if (obs_frz !== exp_frz) begin n_bad++; $display("FAIL rnd%0d_freeze got %0d want %0d", n, obs_frz, exp_frz); end
            n_cmp++;
            if (obs_bub !== 0) begin n_bad++; $display("FAIL rnd%0d_bubble got %0d want 0", n, obs_bub); end
            n_cmp++;
            if (obs_vec !== exp_vec) begin n_bad++; $display("FAIL rnd%0d_outputs got %h want %h", n, obs_vec, exp_vec); end
        end
    endtask

    task automatic test_wait0();
        bit          t_we [5] = '{1, 1, 0, 0, 0};
        bit          t_re [5] = '{0, 0, 1, 1, 0};
        bit          t_wb [5] = '{0, 0, 1, 1, 1};
        logic [31:0] t_ad [5] = '{32'd1036, 32'd1040, 32'd1036, 32'd1296, 32'h0000_0777};
        logic [31:0] t_dt [5] = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 32'h0, 32'h0};
        logic [3:0]  t_ds [5] = '{4'd0, 4'd0, 4'd7, 4'd9, 4'd1};
        logic [31:0] t_rd [5] = '{32'h0, 32'h0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h9ABC_DEF0};
        for (int n = 0; n < 5; n++) begin
            logic [69:0] want;
            @(posedge clk); #1;
            bus0.WB_EN_IN = t_wb[n]; bus0.MEM_R_EN_IN = t_re[n]; bus0.MEM_W_EN_IN = t_we[n];
            bus0.ALU_result_IN = t_ad[n]; bus0.ST_val = t_dt[n]; bus0.Dest_IN = t_ds[n];
            @(negedge clk);
            n_cmp++;
            if (bus0.freeze !== 1'b0) begin n_bad++; $display("FAIL w0_%0d_freeze got %b want 0", n, bus0.freeze); end
            @(posedge clk); #1;
            want = {t_wb[n], t_re[n], t_ds[n], t_ad[n], t_rd[n]};
            n_cmp++;
            if ({bus0.WB_EN, bus0.MEM_R_EN, bus0.Dest, bus0.ALU_result, bus0.Mem_read_value} !== want) begin
                n_bad++;
                $display("FAIL w0_%0d_outputs got %h want %h", n, {bus0.WB_EN, bus0.MEM_R_EN, bus0.Dest, bus0.ALU_result, bus0.Mem_read_value}, want);
            end
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mdl_mem[i] = 32'h0;
            mdl_ok[i]  = 1'b0;
        end
        exp_rd = 0;
        idle_inputs();
        test_reset();
        test_alu_passthrough();
        test_store_load();
        test_wrap_align();
        test_store_priority();
        test_reset_mid_access();
        test_random();
        test_wait0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
